conv2d: RTL and testbench
=========================

# conv2d

Parameterized 2-D convolution layer (NCHW, zero padding, stride) for the inference datapath. It takes a flattened input tensor, weight tensor and per-output-channel bias as wide buses. It computes every output element combinationally from those buses and registers the full output tensor on each clock edge. It is the compute core wrapped by the layer sequencer; operands are expected to be held stable on the ports.

## Interface
- DATA_WIDTH, 32: element width; signed two's-complement fixed point, Q(DATA_WIDTH-16).16
- BATCH_SIZE, 1: batch dimension N
- IN_CHANNELS, 8: input channels C
- OUT_CHANNELS, 32: output channels M
- IN_HEIGHT, 7 / IN_WIDTH, 7: input spatial size H, W
- KERNEL_SIZE, 7: square kernel K
- STRIDE, 1: stride in both dimensions (>=1)
- PADDING, 3: zero padding on every border (>=0)
- Derived: OUT_HEIGHT = (H+2P-K)/STRIDE+1, OUT_WIDTH = (W+2P-K)/STRIDE+1; integer division truncates
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low (0 = in reset)
- input_tensor_flat  in  N*C*H*W*DATA_WIDTH  input elements
- weights_flat  in  M*C*K*K*DATA_WIDTH  kernel elements
- bias_flat  in  M*DATA_WIDTH  bias per output channel
- output_tensor_flat  out  N*M*OUT_HEIGHT*OUT_WIDTH*DATA_WIDTH  registered result

## Operation
- Element e of any bus occupies bits [e*DATA_WIDTH +: DATA_WIDTH]; element 0 is in the LSBs.
- Flat indices:
  - input: ((n*C+c)*H+y)*W+x
  - weight: ((m*C+c)*K+ky)*K+kx
  - bias: m
  - output: ((n*M+m)*OUT_HEIGHT+oy)*OUT_WIDTH+ox
- For each output (n,m,oy,ox):
  - iy = oy*STRIDE+ky-PADDING and ix = ox*STRIDE+kx-PADDING.
  - Taps with iy or ix outside [0,H-1] / [0,W-1] contribute 0.
- Arithmetic:
  - Each tap forms a full-precision signed product in[.]*w[.], 2*DATA_WIDTH bits, 32 fractional bits.
  - Products are summed in a signed accumulator of 2*DATA_WIDTH+16 bits. No intermediate truncation; accumulation order is irrelevant.
  - bias[m] is sign-extended, shifted left 16 and added to the accumulator.
  - The result is arithmetically shifted right 16, which truncates toward negative infinity.
  - The result saturates to the signed DATA_WIDTH range: 0x7FFFFFFF / 0x80000000 for 32 bits.
- No handshake, valid or done signal. The block is a pure function of its inputs plus one output register stage.
- No internal state other than the output register.

## Timing
- rst=0: output_tensor_flat is forced to all zeros immediately, independent of clk, and held at zero while rst=0.
- rst=1: on every rising clk edge, the whole output register loads the result computed from the bus values present just before the edge.
- Latency is 1 cycle. Inputs changed before edge k appear on the output after edge k.
- Inputs changing every cycle give a new result every cycle (throughput 1 tensor/cycle).
- Reset release: the first edge with rst=1 loads a valid result. The output never holds X after reset.
- Reset asserted mid-operation clears the output at once. The result of the interrupted cycle is discarded.
- The output is glitch-free, since it changes only on the clk edge or on reset assertion.

## Test plan
- Reset: drive nonzero operands, hold rst=0 across several edges -> output all zeros. Release rst -> output valid after the first edge.
- Identity, N=1 C=1 M=1 H=W=3 K=3 P=1 S=1:
  - input 1..9 in Q16.16 (0x00010000..0x00090000)
  - weight centre tap 0x00010000, all other taps 0, bias 0
  - -> output equals input element-for-element.
- Padding/sum, same shape:
  - all inputs 0x00010000, all weights 0x00010000, bias 0x00008000 (0.5)
  - -> corners 0x00048000 (4.5), edges 0x00068000 (6.5), centre 0x00098000 (9.5)
- Stride/negative, H=W=4, K=2, P=0, S=2:
  - input 1.0, weights -0.5 (0xFFFF8000), bias 0
  - -> 2x2 outputs each 0xFFFE0000 (-2.0)
- Saturation: input 0x7FFF0000, weights 0x7FFF0000, K=1 P=0, bias 0x7FFFFFFF -> output 0x7FFFFFFF. Negating the weight -> 0x80000000.
- Default parameters with random Q16.16 operands from files:
  - 1568 outputs match a bit-exact reference model implementing the arithmetic rules above
  - output ordering matches the flat index formula

Source files
------------

// File: rtl/conv2d.sv
// conv2d: parameterised 2-D convolution (NCHW layout, zero padding, stride).
//
// Every output element is computed combinationally from the flattened operand
// buses, and the complete output tensor is captured in a single register stage.
// The layer sequencer must hold operands stable on the ports.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset; clears the output register
//   input_tensor_flat   N*C*H*W elements, flat index ((n*C+c)*H+y)*W+x
//   weights_flat        M*C*K*K elements, flat index ((m*C+c)*K+ky)*K+kx
//   bias_flat           M elements, one per output channel
//   output_tensor_flat  N*M*OH*OW elements, flat index ((n*M+m)*OH+oy)*OW+ox
//
// Element e of every bus sits at bits [e*DATA_WIDTH +: DATA_WIDTH].
// Elements are signed fixed point with 16 fractional bits.
module conv2d #(
  parameter int DATA_WIDTH   = 32,
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 8,
  parameter int OUT_CHANNELS = 32,
  parameter int IN_HEIGHT    = 7,
  parameter int IN_WIDTH     = 7,
  parameter int KERNEL_SIZE  = 7,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 3,
  localparam int OUT_HEIGHT  = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
  localparam int OUT_WIDTH   = (IN_WIDTH + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
  localparam int IN_BITS     = BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH,
  localparam int WT_BITS     = OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH,
  localparam int BIAS_BITS   = OUT_CHANNELS*DATA_WIDTH,
  localparam int OUT_BITS    = BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH*DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_BITS-1:0]   input_tensor_flat,
  input  logic [WT_BITS-1:0]   weights_flat,
  input  logic [BIAS_BITS-1:0] bias_flat,
  output logic [OUT_BITS-1:0]  output_tensor_flat
);

  localparam int FRAC_BITS = 16;
  localparam int PROD_W    = 2*DATA_WIDTH;
  localparam int ACC_W     = PROD_W + FRAC_BITS;

  // Saturation limits of a DATA_WIDTH signed value, widened to accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic        [OUT_BITS-1:0]   next_out;
  logic signed [PROD_W-1:0]     pix_ext;
  logic signed [PROD_W-1:0]     wgt_ext;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      shifted;
  logic        [DATA_WIDTH-1:0] pix;
  logic        [DATA_WIDTH-1:0] wgt;
  logic        [DATA_WIDTH-1:0] bias_val;
  logic        [DATA_WIDTH-1:0] res;
  int                           iy;
  int                           ix;

  // Full convolution. Operands are sign-extended to 2*DATA_WIDTH before the
  // multiply, so the low 2*DATA_WIDTH product bits are exact. Each product is
  // then sign-extended into the accumulator, which has 16 bits of headroom.
  // Taps that land in the padding border are skipped, so they contribute zero.
  always_comb begin
    next_out = '0;
    pix      = '0;
    wgt      = '0;
    pix_ext  = '0;
    wgt_ext  = '0;
    prod     = '0;
    acc      = '0;
    shifted  = '0;
    bias_val = '0;
    res      = '0;
    iy       = 0;
    ix       = 0;
    for (int n = 0; n < BATCH_SIZE; n++) begin
      for (int m = 0; m < OUT_CHANNELS; m++) begin
        for (int oy = 0; oy < OUT_HEIGHT; oy++) begin
          for (int ox = 0; ox < OUT_WIDTH; ox++) begin
            acc = '0;
            for (int c = 0; c < IN_CHANNELS; c++) begin
              for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
                for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                  iy = oy*STRIDE + ky - PADDING;
                  ix = ox*STRIDE + kx - PADDING;
                  if (iy >= 0 && iy < IN_HEIGHT && ix >= 0 && ix < IN_WIDTH) begin
                    pix = input_tensor_flat[(((n*IN_CHANNELS + c)*IN_HEIGHT + iy)*IN_WIDTH + ix)*DATA_WIDTH +: DATA_WIDTH];
                    wgt = weights_flat[(((m*IN_CHANNELS + c)*KERNEL_SIZE + ky)*KERNEL_SIZE + kx)*DATA_WIDTH +: DATA_WIDTH];
                    pix_ext = {{DATA_WIDTH{pix[DATA_WIDTH-1]}}, pix};
                    wgt_ext = {{DATA_WIDTH{wgt[DATA_WIDTH-1]}}, wgt};
                    prod    = pix_ext * wgt_ext;
                    acc     = acc + {{FRAC_BITS{prod[PROD_W-1]}}, prod};
                  end
                end
              end
            end
            // Bias has 16 fractional bits; align it to the 32 of the products
            bias_val = bias_flat[m*DATA_WIDTH +: DATA_WIDTH];
            acc = acc + {{DATA_WIDTH{bias_val[DATA_WIDTH-1]}}, bias_val, {FRAC_BITS{1'b0}}};
            // Arithmetic shift floors toward negative infinity
            shifted = acc >>> FRAC_BITS;
            if (shifted > SAT_MAX) begin
              res = SAT_MAX[DATA_WIDTH-1:0];
            end else if (shifted < SAT_MIN) begin
              res = SAT_MIN[DATA_WIDTH-1:0];
            end else begin
              res = shifted[DATA_WIDTH-1:0];
            end
            next_out[(((n*OUT_CHANNELS + m)*OUT_HEIGHT + oy)*OUT_WIDTH + ox)*DATA_WIDTH +: DATA_WIDTH] = res;
          end
        end
      end
    end
  end

  // Single output register stage. Reset clears it immediately, without waiting
  // for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_tensor_flat <= '0;
    end else begin
      output_tensor_flat <= next_out;
    end
  end

endmodule

// File: tb/tb_conv2d.sv
// tb_conv2d: self-checking bench for conv2d.
//
// Four small instances share one clock and one reset:
//   u_id  : 3x3 input, 3x3 kernel, pad 1, stride 1 (identity and padding sums)
//   u_st  : 4x4 input, 2x2 kernel, pad 0, stride 2 (stride with negative weights)
//   u_sat : 1x1 input, 1x1 kernel (saturation and rounding corners)
//   u_rnd : N=2 C=2 M=3, 5x4 input, 3x3 kernel, pad 1, stride 2 (random operands)
// Expected words go into a queue when operands are driven. They are popped
// in output flat order once the clock edge has registered the result.
module tb_conv2d;

  localparam int DW  = 32;
  localparam int RN  = 2;
  localparam int RC  = 2;
  localparam int RM  = 3;
  localparam int RH  = 5;
  localparam int RW  = 4;
  localparam int RK  = 3;
  localparam int RP  = 1;
  localparam int RS  = 2;
  localparam int ROH = (RH + 2*RP - RK) / RS + 1;
  localparam int ROW = (RW + 2*RP - RK) / RS + 1;
  localparam int R_IN  = RN*RC*RH*RW;
  localparam int R_WT  = RM*RC*RK*RK;
  localparam int R_OUT = RN*RM*ROH*ROW;
  localparam int MAX_WORDS = 36;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [9*DW-1:0]     id_in, id_w, id_out;
  logic [DW-1:0]       id_b;
  logic [16*DW-1:0]    st_in;
  logic [4*DW-1:0]     st_w, st_out;
  logic [DW-1:0]       st_b;
  logic [DW-1:0]       sat_in, sat_w, sat_b, sat_out;
  logic [R_IN*DW-1:0]  rnd_in;
  logic [R_WT*DW-1:0]  rnd_w;
  logic [RM*DW-1:0]    rnd_b;
  logic [R_OUT*DW-1:0] rnd_out;

  int rin [R_IN];
  int rwt [R_WT];
  int rb  [RM];

  logic [DW-1:0] exp_q [$];
  int n_compared   = 0;
  int n_mismatched = 0;

  conv2d #(.DATA_WIDTH(DW), .BATCH_SIZE(1), .IN_CHANNELS(1), .OUT_CHANNELS(1),
           .IN_HEIGHT(3), .IN_WIDTH(3), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1))
    u_id (.clk(clk), .rst(rst), .input_tensor_flat(id_in), .weights_flat(id_w),
          .bias_flat(id_b), .output_tensor_flat(id_out));

  conv2d #(.DATA_WIDTH(DW), .BATCH_SIZE(1), .IN_CHANNELS(1), .OUT_CHANNELS(1),
           .IN_HEIGHT(4), .IN_WIDTH(4), .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0))
    u_st (.clk(clk), .rst(rst), .input_tensor_flat(st_in), .weights_flat(st_w),
          .bias_flat(st_b), .output_tensor_flat(st_out));

  conv2d #(.DATA_WIDTH(DW), .BATCH_SIZE(1), .IN_CHANNELS(1), .OUT_CHANNELS(1),
           .IN_HEIGHT(1), .IN_WIDTH(1), .KERNEL_SIZE(1), .STRIDE(1), .PADDING(0))
    u_sat (.clk(clk), .rst(rst), .input_tensor_flat(sat_in), .weights_flat(sat_w),
           .bias_flat(sat_b), .output_tensor_flat(sat_out));

  conv2d #(.DATA_WIDTH(DW), .BATCH_SIZE(RN), .IN_CHANNELS(RC), .OUT_CHANNELS(RM),
           .IN_HEIGHT(RH), .IN_WIDTH(RW), .KERNEL_SIZE(RK), .STRIDE(RS), .PADDING(RP))
    u_rnd (.clk(clk), .rst(rst), .input_tensor_flat(rnd_in), .weights_flat(rnd_w),
           .bias_flat(rnd_b), .output_tensor_flat(rnd_out));

  always #5 clk = ~clk;

  // One comparison: counts it and reports any mismatch
  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pops count expected words and compares them against the bus in flat order
  task automatic pop_check(input string tag, input logic [MAX_WORDS*DW-1:0] bus, input int count);
    for (int e = 0; e < count; e++) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $error("[TB] FAIL %s[%0d] scoreboard empty observed=%h expected=queued word", tag, e, bus[e*DW +: DW]);
      end else begin
        check_word($sformatf("%s[%0d]", tag, e), bus[e*DW +: DW], exp_q.pop_front());
      end
    end
  endtask

  // Every word of the bus must be zero
  task automatic check_zero(input string tag, input logic [MAX_WORDS*DW-1:0] bus, input int count);
    for (int e = 0; e < count; e++) begin
      check_word($sformatf("%s[%0d]", tag, e), bus[e*DW +: DW], '0);
    end
  endtask

  // Bit-exact reference for one output of the random-shape instance
  function automatic logic [DW-1:0] ref_out(input int n, input int m, input int oy, input int ox);
    longint acc;
    int     iy;
    int     ix;
    acc = 0;
    for (int c = 0; c < RC; c++) begin
      for (int ky = 0; ky < RK; ky++) begin
        for (int kx = 0; kx < RK; kx++) begin
          iy = oy*RS + ky - RP;
          ix = ox*RS + kx - RP;
          if (iy >= 0 && iy < RH && ix >= 0 && ix < RW) begin
            acc += longint'(rin[((n*RC + c)*RH + iy)*RW + ix]) * longint'(rwt[((m*RC + c)*RK + ky)*RK + kx]);
          end
        end
      end
    end
    acc += longint'(rb[m]) * 64'sd65536;
    acc = acc >>> 16;
    if (acc > 64'sd2147483647) return 32'h7FFFFFFF;
    if (acc < -64'sd2147483648) return 32'h80000000;
    return acc[DW-1:0];
  endfunction

  // New random operands for u_rnd. Magnitudes below 128.0 keep the reference
  // accumulation within 64 bits while still reaching saturation sometimes.
  task automatic apply_stimulus_rnd();
    for (int e = 0; e < R_IN; e++) rin[e] = int'($urandom_range(0, 32'h00FFFFFF)) - 8388608;
    for (int e = 0; e < R_WT; e++) rwt[e] = int'($urandom_range(0, 32'h00FFFFFF)) - 8388608;
    for (int e = 0; e < RM; e++)   rb[e]  = int'($urandom());
    for (int e = 0; e < R_IN; e++) rnd_in[e*DW +: DW] = rin[e];
    for (int e = 0; e < R_WT; e++) rnd_w[e*DW +: DW]  = rwt[e];
    for (int e = 0; e < RM; e++)   rnd_b[e*DW +: DW]  = rb[e];
  endtask

  task automatic push_rnd_expected();
    for (int n = 0; n < RN; n++)
      for (int m = 0; m < RM; m++)
        for (int oy = 0; oy < ROH; oy++)
          for (int ox = 0; ox < ROW; ox++)
            exp_q.push_back(ref_out(n, m, oy, ox));
  endtask

  task automatic sat_case(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] w,
                          input logic [DW-1:0] b, input logic [DW-1:0] expv);
    @(negedge clk);
    sat_in = a;
    sat_w  = w;
    sat_b  = b;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    pop_check(tag, sat_out, 1);
  endtask

  initial begin
    // Reset held with nonzero operands on every instance
    for (int e = 0; e < 9; e++) id_in[e*DW +: DW] = (e + 1) << 16;
    id_w = '0;
    id_w[4*DW +: DW] = 32'h00010000;
    id_b = '0;
    for (int e = 0; e < 16; e++) st_in[e*DW +: DW] = 32'h00010000;
    for (int e = 0; e < 4; e++)  st_w[e*DW +: DW]  = 32'hFFFF8000;
    st_b   = '0;
    sat_in = 32'h00010000;
    sat_w  = 32'h00010000;
    sat_b  = 32'h00010000;
    apply_stimulus_rnd();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_id", id_out, 9);
    check_zero("reset_st", st_out, 4);
    check_zero("reset_sat", sat_out, 1);
    check_zero("reset_rnd", rnd_out, R_OUT);

    // Identity kernel: the first edge after release must give a valid result
    @(negedge clk);
    rst = 1'b1;
    for (int e = 0; e < 9; e++) exp_q.push_back((e + 1) << 16);
    @(posedge clk);
    #1;
    pop_check("identity", id_out, 9);

    // Padding sums, plus a check that the output holds until the next edge
    @(negedge clk);
    for (int e = 0; e < 9; e++) id_in[e*DW +: DW] = 32'h00010000;
    for (int e = 0; e < 9; e++) id_w[e*DW +: DW]  = 32'h00010000;
    id_b = 32'h00008000;
    #1;
    check_word("hold_before_edge", id_out[4*DW +: DW], 32'h00050000);
    exp_q.push_back(32'h00048000); exp_q.push_back(32'h00068000); exp_q.push_back(32'h00048000);
    exp_q.push_back(32'h00068000); exp_q.push_back(32'h00098000); exp_q.push_back(32'h00068000);
    exp_q.push_back(32'h00048000); exp_q.push_back(32'h00068000); exp_q.push_back(32'h00048000);
    @(posedge clk);
    #1;
    pop_check("padding", id_out, 9);

    // Stride 2 with -0.5 weights: every output is -2.0
    for (int e = 0; e < 4; e++) exp_q.push_back(32'hFFFE0000);
    pop_check("stride", st_out, 4);

    // Saturation and floor rounding corners
    sat_case("sat_pos",   32'h7FFF0000, 32'h7FFF0000, 32'h7FFFFFFF, 32'h7FFFFFFF);
    sat_case("sat_neg",   32'h7FFF0000, 32'h80010000, 32'h7FFFFFFF, 32'h80000000);
    sat_case("neg_1p5",   32'hFFFE8000, 32'h00010000, 32'h00000000, 32'hFFFE8000);
    sat_case("floor_neg", 32'hFFFFFFFF, 32'h00008000, 32'h00000000, 32'hFFFFFFFF);
    sat_case("floor_pos", 32'h00000001, 32'h00008000, 32'h00000000, 32'h00000000);

    // Random operands, new tensor every cycle
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      apply_stimulus_rnd();
      push_rnd_expected();
      @(posedge clk);
      #1;
      pop_check($sformatf("rnd%0d", r), rnd_out, R_OUT);
    end

    // Reset asserted between edges clears the output immediately
    @(negedge clk);
    apply_stimulus_rnd();
    #2;
    rst = 1'b0;
    #1;
    check_zero("midreset_rnd", rnd_out, R_OUT);
    check_zero("midreset_id", id_out, 9);
    @(posedge clk);
    #1;
    check_zero("reset_hold_rnd", rnd_out, 4);
    @(negedge clk);
    rst = 1'b1;
    push_rnd_expected();
    @(posedge clk);
    #1;
    pop_check("after_midreset", rnd_out, R_OUT);

    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
